// File: rtl/sda_kernel_ctrl_reg_multi_if.sv
// Register bus plus per-channel go/done handshake pairs of the multi-channel kernel control block.
// The slave modport is the control block; the master modport is the bus host and the actions.
interface sda_kernel_ctrl_reg_multi_if #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned NUM_CHANNELS = 4
);
  logic                    reg_req;
  logic                    reg_ack;
  logic                    reg_write_en;
  logic [ADDR_WIDTH-1:0]   reg_addr;
  logic [31:0]             reg_wdata;
  logic [3:0]              reg_wstrb;
  logic [31:0]             reg_rdata;
  logic [NUM_CHANNELS-1:0] go_r;
  logic [NUM_CHANNELS-1:0] go_a;
  logic [NUM_CHANNELS-1:0] done_r;
  logic [NUM_CHANNELS-1:0] done_a;

  modport master (
    output reg_req,
    output reg_write_en,
    output reg_addr,
    output reg_wdata,
    output reg_wstrb,
    output go_a,
    output done_r,
    input  reg_ack,
    input  reg_rdata,
    input  go_r,
    input  done_a
  );

  modport slave (
    input  reg_req,
    input  reg_write_en,
    input  reg_addr,
    input  reg_wdata,
    input  reg_wstrb,
    input  go_a,
    input  done_r,
    output reg_ack,
    output reg_rdata,
    output go_r,
    output done_a
  );
endinterface

// File: rtl/sda_kernel_ctrl_reg_multi.sv
// Run/status register set for NUM_CHANNELS independent action channels: per-channel CTRL with
// auto-restart, shared GIE/IER/ISR, and one go/done handshake pair per channel.
module sda_kernel_ctrl_reg_multi #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DECODE_LIMIT = 63
) (
  input  logic                              clk,
  input  logic                              reset,
  sda_kernel_ctrl_reg_multi_if.slave        bus,
  output logic                              interrupt
);
  localparam int unsigned N = NUM_CHANNELS;

  typedef enum logic [1:0] {
    StIdle,
    StGo,
    StBusy
  } state_e;

  state_e       state_q [N];
  state_e       state_d [N];

  logic [N-1:0] ap_start_q;
  logic [N-1:0] ap_start_d;
  logic [N-1:0] ap_done_q;
  logic [N-1:0] ap_done_d;
  logic [N-1:0] ap_ready_q;
  logic [N-1:0] ap_ready_d;
  logic [N-1:0] auto_restart_q;
  logic [N-1:0] auto_restart_d;
  logic [N-1:0] ier_q;
  logic [N-1:0] ier_d;
  logic [N-1:0] isr_q;
  logic [N-1:0] isr_d;
  logic         gie_q;
  logic         gie_d;
  logic         ack_q;
  logic         ack_d;
  logic [31:0]  rdata_q;
  logic [31:0]  rdata_d;
  logic         irq_q;
  logic         irq_d;

  logic         in_range;
  logic         wr_en;
  logic         rd_en;
  logic [31:0]  word_idx;
  logic         sel_gie;
  logic         sel_ier;
  logic         sel_isr;
  logic [N-1:0] sel_ctrl;
  logic [N-1:0] go_valid;
  logic [N-1:0] done_stop;
  logic [N-1:0] go_xfer;
  logic [N-1:0] done_xfer;
  logic         unused_bits;

  // Only byte 0 carries defined bits, so a write without wstrb[0] changes nothing.
  assign unused_bits = ^{bus.reg_wdata, bus.reg_wstrb, bus.reg_addr};

  always_comb begin
    word_idx = 32'(bus.reg_addr[ADDR_WIDTH-1:2]);
    in_range = 32'(bus.reg_addr) <= 32'(DECODE_LIMIT);
    wr_en    = bus.reg_req & in_range & bus.reg_write_en & bus.reg_wstrb[0];
    rd_en    = bus.reg_req & in_range & ~bus.reg_write_en;
    sel_gie  = word_idx == 32'd1;
    sel_ier  = word_idx == 32'd2;
    sel_isr  = word_idx == 32'd3;
    sel_ctrl = '0;
    for (int c = 0; c < int'(N); c++) begin
      if (c == 0) begin
        sel_ctrl[c] = word_idx == 32'd0;
      end else begin
        sel_ctrl[c] = word_idx == 32'(c + 3);
      end
    end
  end

  // Handshake outputs depend on state alone.
  always_comb begin
    go_valid  = '0;
    done_stop = '0;
    for (int c = 0; c < int'(N); c++) begin
      go_valid[c]  = state_q[c] == StGo;
      done_stop[c] = state_q[c] != StBusy;
    end
  end

  assign go_xfer    = go_valid & ~bus.go_a;
  assign done_xfer  = bus.done_r & ~done_stop;
  assign bus.go_r   = go_valid;
  assign bus.done_a = done_stop;

  // Bus writes and clear-on-read are applied first so FSM set events override them.
  always_comb begin
    ap_start_d     = ap_start_q;
    ap_done_d      = ap_done_q;
    ap_ready_d     = ap_ready_q;
    auto_restart_d = auto_restart_q;
    ier_d          = ier_q;
    isr_d          = isr_q;
    gie_d          = gie_q;
    for (int c = 0; c < int'(N); c++) begin
      state_d[c] = state_q[c];
    end

    if (wr_en && sel_gie) gie_d = bus.reg_wdata[0];
    if (wr_en && sel_ier) ier_d = bus.reg_wdata[N-1:0];
    if (wr_en && sel_isr) isr_d = isr_q ^ bus.reg_wdata[N-1:0];

    for (int c = 0; c < int'(N); c++) begin
      if (sel_ctrl[c]) begin
        if (wr_en) begin
          auto_restart_d[c] = bus.reg_wdata[7];
          // A run in flight cannot be re-armed or aborted from the bus.
          if (bus.reg_wdata[0] && state_q[c] == StIdle) ap_start_d[c] = 1'b1;
        end
        if (rd_en) begin
          ap_done_d[c]  = 1'b0;
          ap_ready_d[c] = 1'b0;
        end
      end

      unique case (state_q[c])
        StIdle: begin
          if (ap_start_q[c]) state_d[c] = StGo;
        end
        StGo: begin
          if (go_xfer[c]) begin
            ap_ready_d[c] = 1'b1;
            if (!auto_restart_q[c]) ap_start_d[c] = 1'b0;
            state_d[c] = StBusy;
          end
        end
        StBusy: begin
          if (done_xfer[c]) begin
            ap_done_d[c] = 1'b1;
            if (ier_q[c]) isr_d[c] = 1'b1;
            state_d[c] = auto_restart_q[c] ? StGo : StIdle;
          end
        end
        default: state_d[c] = StIdle;
      endcase
    end
  end

  // Read data is registered and forced to zero outside read acknowledges.
  always_comb begin
    rdata_d = '0;
    ack_d   = bus.reg_req & in_range;
    irq_d   = gie_q & (|(isr_q & ier_q));
    if (rd_en) begin
      if (sel_gie) rdata_d[0] = gie_q;
      if (sel_ier) rdata_d[N-1:0] = ier_q;
      if (sel_isr) rdata_d[N-1:0] = isr_q;
      for (int c = 0; c < int'(N); c++) begin
        if (sel_ctrl[c]) begin
          rdata_d[7:0] = {auto_restart_q[c], 3'b000, ap_ready_q[c], state_q[c] == StIdle,
                          ap_done_q[c], ap_start_q[c]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < int'(N); c++) begin
        state_q[c] <= StIdle;
      end
      ap_start_q     <= '0;
      ap_done_q      <= '0;
      ap_ready_q     <= '0;
      auto_restart_q <= '0;
      ier_q          <= '0;
      isr_q          <= '0;
      gie_q          <= 1'b0;
      ack_q          <= 1'b0;
      rdata_q        <= '0;
      irq_q          <= 1'b0;
    end else begin
      for (int c = 0; c < int'(N); c++) begin
        state_q[c] <= state_d[c];
      end
      ap_start_q     <= ap_start_d;
      ap_done_q      <= ap_done_d;
      ap_ready_q     <= ap_ready_d;
      auto_restart_q <= auto_restart_d;
      ier_q          <= ier_d;
      isr_q          <= isr_d;
      gie_q          <= gie_d;
      ack_q          <= ack_d;
      rdata_q        <= rdata_d;
      irq_q          <= irq_d;
    end
  end

  assign bus.reg_ack   = ack_q;
  assign bus.reg_rdata = rdata_q;
  assign interrupt     = irq_q;
endmodule

// File: tb/tb_sda_kernel_ctrl_reg_multi.sv
// Bench for the multi-channel kernel control block: timing and register expectations come from
// the register map and handshake rules, with randomized channel choice and action latencies.
module tb_sda_kernel_ctrl_reg_multi;
  localparam int unsigned AW    = 12;
  localparam int unsigned NCH   = 4;
  localparam int unsigned LIMIT = 63;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic interrupt;

  sda_kernel_ctrl_reg_multi_if #(.ADDR_WIDTH(AW), .NUM_CHANNELS(NCH)) bus ();

  sda_kernel_ctrl_reg_multi #(
    .ADDR_WIDTH  (AW),
    .NUM_CHANNELS(NCH),
    .DECODE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int go_cnt   [NCH] = '{default: 0};
  int done_cnt [NCH] = '{default: 0};

  // Handshake transfers counted mid-cycle while inputs and state are stable.
  always @(negedge clk) begin
    for (int c = 0; c < int'(NCH); c++) begin
      if (bus.go_r[c] && !bus.go_a[c]) go_cnt[c] <= go_cnt[c] + 1;
      if (bus.done_r[c] && !bus.done_a[c]) done_cnt[c] <= done_cnt[c] + 1;
    end
  end

  function automatic logic [AW-1:0] ctrl_addr(input int c);
    if (c == 0) return '0;
    return AW'(16 + 4 * (c - 1));
  endfunction

  function automatic logic [31:0] exp_ctrl(input bit start, input bit done, input bit idle,
                                           input bit ready, input bit auto_r);
    return {24'd0, auto_r, 3'd0, ready, idle, done, start};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.reg_req = 1'b1; bus.reg_write_en = 1'b1; bus.reg_addr = a;
    bus.reg_wdata = d; bus.reg_wstrb = s;
    step();
    bus.reg_req = 1'b0; bus.reg_write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic ack, output logic [31:0] d);
    bus.reg_req = 1'b1; bus.reg_write_en = 1'b0; bus.reg_addr = a;
    step();
    ack = bus.reg_ack;
    d = bus.reg_rdata;
    bus.reg_req = 1'b0;
  endtask

  task automatic test_reset();
    logic ack;
    logic [31:0] d;
    logic [AW-1:0] a;
    reset = 1'b1;
    repeat (3) step();
    n_cmp++; if (bus.go_r !== 4'b0000) begin n_err++; $display("FAIL reset_go_r got %b want 0000", bus.go_r); end
    n_cmp++; if (bus.done_a !== 4'b1111) begin n_err++; $display("FAIL reset_done_a got %b want 1111", bus.done_a); end
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", interrupt); end
    n_cmp++; if (bus.reg_ack !== 1'b0 || bus.reg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_bus got ack=%b rdata=%h want 0/0", bus.reg_ack, bus.reg_rdata); end
    reset = 1'b0;
    step();
    bus_read('0, ack, d);
    n_cmp++; if (ack !== 1'b1 || d !== exp_ctrl(0, 0, 1, 0, 0)) begin n_err++; $display("FAIL reset_ctrl0 got ack=%b %h want 1/%h", ack, d, exp_ctrl(0, 0, 1, 0, 0)); end
    for (int i = 1; i <= 3; i++) begin
      a = AW'(4 * i);
      bus_read(a, ack, d);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_reg_%h got %h want 0", a, d); end
    end
    for (int c = 1; c < int'(NCH); c++) begin
      bus_read(ctrl_addr(c), ack, d);
      n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL reset_ctrl%0d got %h want 4", c, d); end
    end
  endtask

  task automatic test_single_run();
    logic ack;
    logic [31:0] d;
    int c, acc, lat;
    bus_write(AW'(8), 32'hF, 4'hF);
    bus_write(AW'(4), 32'h1, 4'hF);
    for (int it = 0; it < 5; it++) begin
      c   = (it == 0) ? 0 : int'($urandom_range(0, NCH - 1));
      acc = (it == 0) ? 3 : int'($urandom_range(0, 5));
      lat = (it == 0) ? 10 : int'($urandom_range(1, 12));
      bus_write(ctrl_addr(c), 32'h1, 4'hF);
      n_cmp++; if (bus.go_r[c] !== 1'b0) begin n_err++; $display("FAIL run%0d_go_early ch%0d got 1 want 0", it, c); end
      step();
      n_cmp++; if (bus.go_r[c] !== 1'b1) begin n_err++; $display("FAIL run%0d_go_t2 ch%0d got %b want 1", it, c, bus.go_r[c]); end
      repeat (acc) step();
      n_cmp++; if (bus.go_r[c] !== 1'b1) begin n_err++; $display("FAIL run%0d_go_hold ch%0d got %b want 1", it, c, bus.go_r[c]); end
      bus.go_a[c] = 1'b0;
      step();
      bus.go_a[c] = 1'b1;
      n_cmp++; if (bus.go_r[c] !== 1'b0 || bus.done_a[c] !== 1'b0) begin n_err++; $display("FAIL run%0d_busy ch%0d got go=%b done_a=%b want 0/0", it, c, bus.go_r[c], bus.done_a[c]); end
      repeat (lat - 1) step();
      n_cmp++; if (bus.done_a[c] !== 1'b0) begin n_err++; $display("FAIL run%0d_done_a ch%0d got 1 want 0", it, c); end
      bus.done_r[c] = 1'b1;
      step();
      bus.done_r[c] = 1'b0;
      n_cmp++; if (bus.done_a[c] !== 1'b1 || interrupt !== 1'b0) begin n_err++; $display("FAIL run%0d_d1 ch%0d got done_a=%b irq=%b want 1/0", it, c, bus.done_a[c], interrupt); end
      step();
      n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL run%0d_irq ch%0d got 0 want 1", it, c); end
      bus_read(ctrl_addr(c), ack, d);
      n_cmp++; if (d !== exp_ctrl(0, 1, 1, 1, 0)) begin n_err++; $display("FAIL run%0d_ctrl ch%0d got %h want %h", it, c, d, exp_ctrl(0, 1, 1, 1, 0)); end
      bus_read(ctrl_addr(c), ack, d);
      n_cmp++; if (d !== exp_ctrl(0, 0, 1, 0, 0)) begin n_err++; $display("FAIL run%0d_ctrl_cor ch%0d got %h want 4", it, c, d); end
      bus_read(AW'(12), ack, d);
      n_cmp++; if (d !== (32'h1 << c)) begin n_err++; $display("FAIL run%0d_isr got %h want %h", it, d, 32'h1 << c); end
      bus_write(AW'(12), 32'h1 << c, 4'hF);
      step();
      n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL run%0d_irq_clr got 1 want 0", it); end
    end
  endtask

  task automatic test_auto_restart();
    logic ack;
    logic [31:0] d;
    int g0, d0, lat;
    g0 = go_cnt[2];
    d0 = done_cnt[2];
    bus.go_a[2] = 1'b0;
    bus_write(AW'(20), 32'h81, 4'hF);
    step();
    n_cmp++; if (bus.go_r[2] !== 1'b1) begin n_err++; $display("FAIL auto_go_first got 0 want 1"); end
    step();
    for (int k = 0; k < 3; k++) begin
      lat = int'($urandom_range(1, 6));
      repeat (lat - 1) step();
      n_cmp++; if (bus.done_a[2] !== 1'b0) begin n_err++; $display("FAIL auto%0d_busy got done_a=1 want 0", k); end
      bus.done_r[2] = 1'b1;
      step();
      bus.done_r[2] = 1'b0;
      n_cmp++; if (bus.go_r[2] !== 1'b1) begin n_err++; $display("FAIL auto%0d_rego got 0 want 1", k); end
      step();
    end
    n_cmp++; if (go_cnt[2] - g0 != 4 || done_cnt[2] - d0 != 3) begin n_err++; $display("FAIL auto_counts got go=%0d done=%0d want 4/3", go_cnt[2] - g0, done_cnt[2] - d0); end
    bus_write(AW'(20), 32'h0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      lat = int'($urandom_range(1, 6));
      repeat (lat - 1) step();
      bus.done_r[2] = 1'b1;
      step();
      bus.done_r[2] = 1'b0;
      n_cmp++; if (bus.go_r[2] !== 1'b0) begin n_err++; $display("FAIL auto_stop%0d_idle got go=1 want 0", k); end
      step();
      if (k == 0) begin
        n_cmp++; if (bus.go_r[2] !== 1'b1) begin n_err++; $display("FAIL auto_last_run got go=0 want 1"); end
        step();
      end
    end
    repeat (6) step();
    n_cmp++; if (go_cnt[2] - g0 != 5 || done_cnt[2] - d0 != 5 || bus.go_r[2] !== 1'b0) begin n_err++; $display("FAIL auto_final got go=%0d done=%0d go_r=%b want 5/5/0", go_cnt[2] - g0, done_cnt[2] - d0, bus.go_r[2]); end
    bus.go_a[2] = 1'b1;
    bus_read(AW'(20), ack, d);
    n_cmp++; if (d !== exp_ctrl(0, 1, 1, 1, 0)) begin n_err++; $display("FAIL auto_ctrl got %h want %h", d, exp_ctrl(0, 1, 1, 1, 0)); end
    bus_read(AW'(12), ack, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL auto_isr got %h want 4", d); end
    bus_write(AW'(12), 32'h4, 4'hF);
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [31:0] d;
    int held;
    bus.go_a = 4'b0010;
    for (int c = 0; c < int'(NCH); c++) bus_write(ctrl_addr(c), 32'h1, 4'hF);
    repeat (2) step();
    n_cmp++; if (bus.go_r !== 4'b0010 || bus.done_a !== 4'b0010) begin n_err++; $display("FAIL b2b_states got go=%b done_a=%b want 0010/0010", bus.go_r, bus.done_a); end
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.go_r[1] === 1'b1) held++;
      step();
    end
    n_cmp++; if (held != 20) begin n_err++; $display("FAIL b2b_go1_held got %0d want 20", held); end
    bus.go_a[1] = 1'b0;
    step();
    bus.go_a = 4'b1111;
    n_cmp++; if (bus.go_r !== 4'b0000 || bus.done_a !== 4'b0000) begin n_err++; $display("FAIL b2b_all_busy got go=%b done_a=%b want 0000/0000", bus.go_r, bus.done_a); end
    bus.done_r = 4'b0001;
    bus_read(ctrl_addr(0), ack, d);
    n_cmp++; if (d !== exp_ctrl(0, 0, 0, 1, 0)) begin n_err++; $display("FAIL b2b_rd0_race got %h want 8", d); end
    bus.done_r = 4'b1000;
    bus_read(ctrl_addr(3), ack, d);
    bus.done_r = 4'b0000;
    n_cmp++; if (d !== exp_ctrl(0, 0, 0, 1, 0)) begin n_err++; $display("FAIL b2b_rd3_race got %h want 8", d); end
    bus_read(ctrl_addr(0), ack, d);
    n_cmp++; if (d !== exp_ctrl(0, 1, 1, 0, 0)) begin n_err++; $display("FAIL b2b_done0_kept got %h want 6", d); end
    bus_read(ctrl_addr(3), ack, d);
    n_cmp++; if (d !== exp_ctrl(0, 1, 1, 0, 0)) begin n_err++; $display("FAIL b2b_done3_kept got %h want 6", d); end
    bus.done_r = 4'b0010;
    step();
    bus.done_r = 4'b0000;
    bus_read(AW'(12), ack, d);
    n_cmp++; if (d !== 32'hB || interrupt !== 1'b1) begin n_err++; $display("FAIL b2b_isr got %h irq=%b want b/1", d, interrupt); end
    bus.done_r = 4'b0100;
    bus_write(AW'(12), 32'hF, 4'hF);
    bus.done_r = 4'b0000;
    bus_read(AW'(12), ack, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL b2b_isr_set_wins got %h want 4", d); end
    bus_write(AW'(12), 32'h4, 4'hF);
    bus_read(ctrl_addr(1), ack, d);
    n_cmp++; if (d !== exp_ctrl(0, 1, 1, 1, 0)) begin n_err++; $display("FAIL b2b_ctrl1 got %h want e", d); end
    bus_read(ctrl_addr(2), ack, d);
    n_cmp++; if (d !== exp_ctrl(0, 1, 1, 1, 0)) begin n_err++; $display("FAIL b2b_ctrl2 got %h want e", d); end
    n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL b2b_irq_clr got 1 want 0"); end
  endtask

  task automatic test_boundary();
    logic ack;
    logic [31:0] d;
    bus_write('0, 32'h1, 4'hE);
    repeat (3) step();
    n_cmp++; if (bus.go_r[0] !== 1'b0) begin n_err++; $display("FAIL bnd_wstrb_go got 1 want 0"); end
    bus_read('0, ack, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL bnd_wstrb_ctrl got %h want 4", d); end
    bus_read(AW'(64), ack, d);
    n_cmp++; if (ack !== 1'b0 || d !== 32'h0) begin n_err++; $display("FAIL bnd_rd_40 got ack=%b %h want 0/0", ack, d); end
    bus_write(AW'(64), 32'h1, 4'hF);
    n_cmp++; if (bus.reg_ack !== 1'b0) begin n_err++; $display("FAIL bnd_wr_40 got ack=1 want 0"); end
    bus_read(AW'(60), ack, d);
    n_cmp++; if (ack !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL bnd_rd_3c got ack=%b %h want 1/0", ack, d); end
    bus_write(AW'(60), 32'hFFFF_FFFF, 4'hF);
    n_cmp++; if (bus.reg_ack !== 1'b1) begin n_err++; $display("FAIL bnd_wr_3c got ack=0 want 1"); end
    bus.done_r[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.done_a[1] !== 1'b1) begin n_err++; $display("FAIL bnd_idle_done_a got 0 want 1"); end
    end
    bus.done_r[1] = 1'b0;
    bus_read(ctrl_addr(1), ack, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL bnd_idle_done_ctrl got %h want 4", d); end
    bus.go_a[0] = 1'b0;
    bus_write('0, 32'h1, 4'hF);
    repeat (2) step();
    n_cmp++; if (bus.done_a[0] !== 1'b0) begin n_err++; $display("FAIL bnd_pre_reset_busy got 1 want 0"); end
    reset = 1'b1;
    step();
    n_cmp++; if (bus.go_r !== 4'b0000 || bus.done_a !== 4'b1111) begin n_err++; $display("FAIL bnd_reset_idle got go=%b done_a=%b want 0000/1111", bus.go_r, bus.done_a); end
    reset = 1'b0;
    bus.go_a = 4'b1111;
    step();
    bus_read('0, ack, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL bnd_reset_ctrl got %h want 4", d); end
    bus_read(AW'(8), ack, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL bnd_reset_ier got %h want 0", d); end
    bus_read(AW'(4), ack, d);
    n_cmp++; if (d !== 32'h0 || interrupt !== 1'b0) begin n_err++; $display("FAIL bnd_reset_gie got %h irq=%b want 0/0", d, interrupt); end
  endtask

  initial begin
    bus.reg_req = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.reg_addr = '0;
    bus.reg_wdata = '0;
    bus.reg_wstrb = '0;
    bus.go_a = 4'b1111;
    bus.done_r = 4'b0000;
    test_reset();
    test_single_run();
    test_auto_restart();
    test_back_to_back();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
